// File: rtl/fmap_stream_packer.sv
// Packs a serial stream of feature-map elements (column, then row, then channel) into one flat vector
// and holds it until the pooling stage takes it. Define FMAP_PACKER_RELU_EN to clamp negatives to 0 on write.
module fmap_stream_packer #(
  parameter int DATA_W = 8,
  parameter int IN_W   = 7,
  parameter int IN_H   = 7,
  parameter int IN_D   = 3,
  localparam int N     = IN_W * IN_H * IN_D,
  localparam int CW    = (IN_W > 1) ? $clog2(IN_W) : 1,
  localparam int RW    = (IN_H > 1) ? $clog2(IN_H) : 1,
  localparam int DW    = (IN_D > 1) ? $clog2(IN_D) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_last,
  output logic [DATA_W*N-1:0] out_vec,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                frame_err,
  output logic [CW-1:0]       col_idx,
  output logic [RW-1:0]       row_idx,
  output logic [DW-1:0]       ch_idx
);

  // Handshakes: a beat transfers on a rising edge where valid & ready are both 1; valid may not wait on ready.
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t            state;
  logic [KW-1:0]     k_q;
  logic              in_ready_q;
  logic              accept;
  logic              is_last_k;
  logic [DATA_W-1:0] wdata;

  // in_ready_q is preset during reset so the port reads 0 only while rst is asserted.
  assign in_ready  = in_ready_q & ~rst;
  assign accept    = in_valid & in_ready;
  assign is_last_k = (k_q == KW'(N - 1));

`ifdef FMAP_PACKER_RELU_EN
  assign wdata = in_data[DATA_W-1] ? '0 : in_data;
`else
  assign wdata = in_data;
`endif

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state      <= FILL;
      k_q        <= '0;
      col_idx    <= '0;
      row_idx    <= '0;
      ch_idx     <= '0;
      out_vec    <= '0;
      out_valid  <= 1'b0;
      frame_err  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      frame_err <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            if (is_last_k) begin
              out_vec[k_q*DATA_W +: DATA_W] <= wdata;
              k_q        <= '0;
              col_idx    <= '0;
              row_idx    <= '0;
              ch_idx     <= '0;
              state      <= HOLD;
              out_valid  <= 1'b1;
              in_ready_q <= 1'b0;
              frame_err  <= ~in_last;
            end else if (in_last) begin
              // Early end of frame: discard the partial map entirely.
              k_q       <= '0;
              col_idx   <= '0;
              row_idx   <= '0;
              ch_idx    <= '0;
              out_vec   <= '0;
              frame_err <= 1'b1;
            end else begin
              out_vec[k_q*DATA_W +: DATA_W] <= wdata;
              k_q <= k_q + 1'b1;
              if (col_idx == CW'(IN_W - 1)) begin
                col_idx <= '0;
                if (row_idx == RW'(IN_H - 1)) begin
                  row_idx <= '0;
                  ch_idx  <= (ch_idx == DW'(IN_D - 1)) ? '0 : ch_idx + 1'b1;
                end else begin
                  row_idx <= row_idx + 1'b1;
                end
              end else begin
                col_idx <= col_idx + 1'b1;
              end
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state      <= FILL;
            out_valid  <= 1'b0;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= FILL;
          out_valid  <= 1'b0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/fmap_stream_packer.md
Name: fmap_stream_packer

Overview:
- Upstream neighbour of the max-pooling stage in the CNN datapath.
- Accepts convolution-engine results as a serial stream, one element per accepted beat, using a valid/ready handshake.
- Packs one full IN_W x IN_H x IN_D feature map into the flat parallel vector the pooling stage consumes, then holds it until the pooling stage takes it.
- Checks frame framing and optionally applies ReLU before storage.

Parameters:
- DATA_W, 8, element width in bits; two's complement.
- IN_W, 7, feature-map width (columns).
- IN_H, 7, feature-map height (rows).
- IN_D, 3, channel count.
- Derived: N = IN_W*IN_H*IN_D, the number of elements per frame (147 at defaults).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous frame abort; clears counters, state and vector.
- in_valid  in  1  stream element present.
- in_ready  out  1  packer can accept an element.
- in_data  in  DATA_W  stream element.
- in_last  in  1  marks the final element of a frame.
- out_vec  out  DATA_W*N  packed feature map, fed to the pooling stage IN bus.
- out_valid  out  1  out_vec holds a complete frame.
- out_ready  in  1  pooling stage accepts the frame.
- frame_err  out  1  one-cycle pulse on a framing error.
- col_idx  out  clog2(IN_W)  current write column (debug).
- row_idx  out  clog2(IN_H)  current write row (debug).
- ch_idx  out  clog2(IN_D)  current write channel (debug).

Behaviour:
- Reset (rst=1) values: state=FILL; counters=0; out_vec=0; out_valid=0; frame_err=0; in_ready=0 during the reset cycle, then 1.
- Priority order: rst > clr > normal operation.
- clr has the same effect as rst, but in_ready stays 1 during the clr cycle.
- Element order:
  - Columns are fastest, then rows, then channels.
  - Index k = ch*IN_H*IN_W + row*IN_W + col.
  - Element k is stored at out_vec[k*DATA_W +: DATA_W].
- States:
  - FILL: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept condition: in_valid & in_ready. Only accepted beats write a slot and advance the counters.
- Counter wrap:
  - col wraps at IN_W-1 and increments row.
  - row wraps at IN_H-1 and increments ch.
  - ch wraps at IN_D-1.
- FILL -> HOLD:
  - Occurs when the element with k=N-1 is accepted.
  - out_valid=1 in the next cycle, i.e. 1-cycle latency from the last accepted beat.
  - Counters return to 0.
- Framing error, early in_last:
  - in_last=1 on an accepted beat with k<N-1.
  - frame_err pulses the next cycle.
  - The partial frame is discarded: counters=0 and out_vec=0.
  - State stays FILL.
- Framing error, missing in_last:
  - in_last=0 on the accepted beat k=N-1.
  - frame_err pulses.
  - The frame is still completed and presented (enters HOLD).
- HOLD:
  - out_vec is stable and out_valid is held until out_ready=1.
  - On out_valid & out_ready, the next cycle is FILL with in_ready=1.
  - out_vec retains its old contents until overwritten.
  - There is no same-cycle fill-through.
- out_ready in FILL is ignored.
- in_valid in HOLD is ignored; no data loss, since in_ready=0.
- Reset or clr mid-frame, or in HOLD: the frame is dropped and no frame_err is raised.
- Width rule: the stored value is in_data bit-exact; there is no extension or truncation.
- frame_err always pulses for exactly one cycle per offending beat.

Optional Feature:
- Macro: FMAP_PACKER_RELU_EN.
- Defined: each accepted in_data with MSB=1 (negative) is stored as 0; non-negative values are stored unchanged. There is no added latency; ReLU sits combinationally on the write path.
- Undefined: raw values are stored. The pooling stage then sees signed data and ReLU is done elsewhere.

Test Plan:
- Normal frame:
  - Stimulus: defaults; stream k=0..146 with in_data=k[7:0] and in_last on k=146; out_ready=1.
  - Response: out_valid one cycle after beat 146; out_vec[k*8+:8]=k for all k; in_ready=0 for exactly one cycle.
- Backpressure:
  - Stimulus: fill a frame, hold out_ready=0 for 20 cycles while in_valid=1.
  - Response: out_vec is stable, in_ready=0 throughout, no writes; after out_ready=1 for one cycle, in_ready=1 and the next frame's first element lands at slot 0.
- Early in_last:
  - Stimulus: in_last on k=50.
  - Response: frame_err=1 for one cycle; counters=0; out_vec=0; the next 147 beats form a correct frame.
- Missing in_last:
  - Stimulus: beat 146 with in_last=0.
  - Response: frame_err pulse and out_valid=1 simultaneously; frame contents are correct.
- Reset and clr mid-frame:
  - Stimulus: assert rst at k=80, or separately clr at k=80.
  - Response: out_vec=0; idx=0/0/0; out_valid=0; no frame_err; the subsequent full frame is correct.
- ReLU:
  - Stimulus: with FMAP_PACKER_RELU_EN, send in_data=8'hF0 at k=0 and 8'h12 at k=1.
  - Response: slot0=8'h00, slot1=8'h12; without the macro, slot0=8'hF0.
